// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// The optional 8E1 frame (parity state and parity_err port) is enabled by
// defining UART_RX_PARITY_EN. The PARITY enum value always exists so that the
// state encoding does not change between builds.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    // Width of a counter that runs 0..clocks_per_bit-1, at least one bit wide.
    function automatic int timer_width(input int clocks_per_bit);
        return (clocks_per_bit > 2) ? $clog2(clocks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// RESET_VAL sets the value both flops take during reset, so an idle-high line
// does not look like a falling edge when reset is released.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the async input through two flops before anything uses it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            // NOTE: non-blocking assignments make both flops sample their
            // pre-edge inputs; blocking here would collapse them into one flop.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: recovers 8N1 bytes (LSB first) from ser_rx, timed by clk_en.
// Define UART_RX_PARITY_EN for 8E1 frames with an even-parity check and a
// parity_err pulse; the default build is 8N1 without the parity_err port.
module uart_rx
    import uart_pkg::*;
#(
    parameter int clocks_per_bit = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic                 ser_rx,
    output logic                 out_valid,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int TW = timer_width(clocks_per_bit);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] BIT_END  = TW'(clocks_per_bit - 1);
    localparam logic [TW-1:0] HALF_END = TW'((clocks_per_bit / 2) - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    rx_state_t            state;
    logic [TW-1:0]        timer;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_s;
    logic                 bit_done;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
`endif

    uart_sync2 #(
        .RESET_VAL (IDLE_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (ser_rx),
        .q   (rx_s)
    );

    // A full bit period has elapsed on this enabled cycle.
    assign bit_done = clk_en && (timer == BIT_END);

    // Busy whenever a frame (or a held-low break) is in progress.
    assign busy = (state != IDLE);

    // Receive state machine; every state change waits for clk_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (clk_en) begin
                case (state)
                    IDLE: begin
                        if (rx_s != IDLE_LEVEL) begin
                            state <= START;
                            timer <= '0;
                        end
                    end
                    // Re-check the start bit half a bit later to reject glitches.
                    START: begin
                        if (timer == HALF_END) begin
                            timer <= '0;
                            if (rx_s != IDLE_LEVEL) begin
                                state   <= DATA;
                                bit_idx <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    // Half a bit was used in START, so these samples are mid-bit.
                    DATA: begin
                        if (bit_done) begin
                            timer   <= '0;
                            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (bit_done) begin
                            timer   <= '0;
                            par_bit <= rx_s;
                            state   <= STOP;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (bit_done) begin
                            timer <= '0;
                            if (rx_s == IDLE_LEVEL) begin
                                state <= IDLE;
`ifdef UART_RX_PARITY_EN
                                if (^{shreg, par_bit} == 1'b0) begin
                                    out_valid <= 1'b1;
                                    out_data  <= shreg;
                                end else begin
                                    parity_err <= 1'b1;
                                end
`else
                                out_valid <= 1'b1;
                                out_data  <= shreg;
`endif
                            end else begin
                                frame_err <= 1'b1;
                                state     <= BREAK;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    // Hold off until the line returns to idle so a stuck-low
                    // line reports a single framing error.
                    BREAK: begin
                        if (rx_s == IDLE_LEVEL) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. Frames are built as plain lists of line
// levels (start, data LSB first, optional parity, stop) and the expected
// outcome of each frame is decided from its stop and parity bits alone.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB = 4;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       clk_en = 1'b0;
    logic       ser_rx = 1'b1;
    logic       out_valid;
    logic [7:0] out_data;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int total = 0;
    int bad   = 0;

    // clk_en pattern: 0 = always on, 1 = two on / two off, 2 = held off.
    int         en_mode  = 0;
    logic [1:0] en_phase = 2'd0;

    // Observed outputs and the reference model's expectations.
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         n_valid  = 0;
    int         n_ferr   = 0;
    int         n_perr   = 0;
    int         exp_ferr = 0;
    int         exp_perr = 0;
    logic [7:0] last_good = 8'h00;

    uart_rx #(
        .clocks_per_bit (CPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .ser_rx     (ser_rx),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Drive clk_en away from the active edge.
    always @(negedge clk) begin
        en_phase = en_phase + 2'd1;
        case (en_mode)
            0:       clk_en = 1'b1;
            1:       clk_en = en_phase[1];
            default: clk_en = 1'b0;
        endcase
    end

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (out_valid) begin
            n_valid++;
            rx_q.push_back(out_data);
        end
        if (frame_err) n_ferr++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) n_perr++;
`endif
        if (out_valid && frame_err) begin
            total++;
            bad++;
            $error("FAIL excl_pulse: out_valid=1 frame_err=1 required not both");
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: what the receiver must report for one frame.
    task automatic expect_frame(input logic [7:0] data, input logic stop_bit, input logic par_bit);
        if (stop_bit == 1'b0) begin
            exp_ferr++;
        end else begin
`ifdef UART_RX_PARITY_EN
            if ((^data ^ par_bit) == 1'b0) begin
                exp_q.push_back(data);
                last_good = data;
            end else begin
                exp_perr++;
            end
`else
            exp_q.push_back(data);
            last_good = data;
`endif
        end
    endtask

    // Wait for an enabled rising edge so bit boundaries line up with clk_en.
    task automatic align();
        int guard = 0;
        @(posedge clk);
        while (!clk_en && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        check("align_timeout", 32'(clk_en), 32'd1);
    endtask

    // Drive one frame; each bit lasts CPB enabled cycles. When abort_at names a
    // bit index, reset is pulsed half-way through that bit and the frame ends.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input logic par_bit, input int abort_at,
                              input bit do_align);
        logic lv[$];
        int   n;
        int   guard;
        lv = {};
        lv.push_back(1'b0);
        for (int i = 0; i < 8; i++) lv.push_back(data[i]);
`ifdef UART_RX_PARITY_EN
        lv.push_back(par_bit);
`endif
        lv.push_back(stop_bit);
        if (do_align) align();
        foreach (lv[i]) begin
            @(negedge clk);
            ser_rx = lv[i];
            n = 0;
            guard = 0;
            while (n < CPB && guard < 1000) begin
                @(posedge clk);
                guard++;
                if (clk_en) n++;
                if (i == abort_at && n == CPB / 2) begin
                    #2 rst = 1'b1;
                    #1;
                    check("rst_busy",      32'(busy),      32'd0);
                    check("rst_out_valid", 32'(out_valid), 32'd0);
                    check("rst_out_data",  32'(out_data),  32'd0);
                    last_good = 8'h00;
                    @(negedge clk);
                    ser_rx = 1'b1;
                    rst    = 1'b0;
                    return;
                end
            end
            check("bit_timeout", 32'(n), 32'(CPB));
        end
    endtask

    // Let the receiver drain, compare against the model, then start afresh.
    task automatic settle_compare(input string tag);
        repeat (16 * CPB) @(posedge clk);
        check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check({tag, "_data"}, 32'(rx_q[i]), 32'(exp_q[i]));
        check({tag, "_ferr"}, 32'(n_ferr), 32'(exp_ferr));
        check({tag, "_perr"}, 32'(n_perr), 32'(exp_perr));
        rx_q.delete();
        exp_q.delete();
        n_valid  = 0;
        n_ferr   = 0;
        n_perr   = 0;
        exp_ferr = 0;
        exp_perr = 0;
    endtask

    initial begin
        logic [7:0] d;

        // Reset values.
        repeat (3) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data",  32'(out_data),  32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_busy",      32'(busy),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // Two frames with no idle time between them.
        send_frame(8'h48, 1'b1, ^8'h48, -1, 1'b1);
        expect_frame(8'h48, 1'b1, ^8'h48);
        send_frame(8'h69, 1'b1, ^8'h69, -1, 1'b0);
        expect_frame(8'h69, 1'b1, ^8'h69);
        settle_compare("b2b");

        // Divided clk_en, random bytes back to back.
        en_mode = 1;
        for (int k = 0; k < 16; k++) begin
            d = 8'($urandom_range(0, 255));
            send_frame(d, 1'b1, ^d, -1, (k == 0));
            expect_frame(d, 1'b1, ^d);
        end
        en_mode = 0;
        settle_compare("div_en");

        // One-cycle glitch must be rejected by the start-bit re-check.
        @(negedge clk);
        ser_rx = 1'b0;
        @(negedge clk);
        ser_rx = 1'b1;
        repeat (CPB / 2 + 2) @(posedge clk);
        #1 check("glitch_busy", 32'(busy), 32'd0);
        settle_compare("glitch");

        // Framing error followed by a line held low for three bit periods.
        send_frame(8'h55, 1'b0, ^8'h55, -1, 1'b1);
        expect_frame(8'h55, 1'b0, ^8'h55);
        repeat (3 * CPB) @(posedge clk);
        #1 check("break_busy", 32'(busy), 32'd1);
        @(negedge clk);
        ser_rx = 1'b1;
        repeat (CPB + 4) @(posedge clk);
        #1 check("ferr_busy_after", 32'(busy), 32'd0);
        check("ferr_out_data", 32'(out_data), 32'(last_good));
        settle_compare("ferr");

        // With clk_en held low a low line must not start a frame.
        en_mode = 2;
        repeat (2) @(negedge clk);
        ser_rx = 1'b0;
        repeat (20) @(posedge clk);
        #1 check("freeze_busy", 32'(busy), 32'd0);
        @(negedge clk);
        ser_rx = 1'b1;
        repeat (4) @(posedge clk);
        en_mode = 0;
        settle_compare("freeze");

        // Reset during data bit 4 of 0xA5, then a clean 0x3C.
        send_frame(8'hA5, 1'b1, ^8'hA5, 5, 1'b1);
        repeat (4) @(posedge clk);
        send_frame(8'h3C, 1'b1, ^8'h3C, -1, 1'b1);
        expect_frame(8'h3C, 1'b1, ^8'h3C);
        settle_compare("rst_mid");

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 needs a parity bit of 1.
        send_frame(8'h07, 1'b1, 1'b1, -1, 1'b1);
        expect_frame(8'h07, 1'b1, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0, -1, 1'b1);
        expect_frame(8'h07, 1'b1, 1'b0);
        settle_compare("parity");
        check("parity_out_data", 32'(out_data), 32'(last_good));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
